decrypt_requester: RTL



---
 rtl/decrypt_requester.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/decrypt_requester.sv
// ---------------------------------------------------------------------------
// decrypt_requester
//
// Initiator side of the decrypt engine's start/done handshake. The block
// accepts one job at a time from an upstream valid/ready source and sends the
// engine a one-cycle start pulse. It then waits for done under a watchdog. If
// the watchdog expires it re-issues the job up to MAX_RETRY times. Finally it
// returns a response upstream that carries the job id, a timeout flag and the
// number of start pulses issued. Every accepted job therefore ends in exactly
// one response, even when the engine never answers.
//
// Ports
//   clk           : single clock, all logic on posedge
//   rst           : asynchronous, active-high reset
//   job_valid     : upstream job request
//   job_ready     : block can accept a job (high only in IDLE)
//   job_id        : job identifier, captured on accept
//   start         : one-cycle start pulse to the engine
//   done          : engine completion pulse
//   resp_valid    : response available (held until resp_ready)
//   resp_ready    : upstream takes the response
//   resp_id       : captured job_id
//   resp_timeout  : 1 = every attempt timed out
//   resp_attempts : start pulses issued for this job, saturating at 3
//   busy          : block is not idle
//   err_spurious  : sticky, done seen while not waiting for it
// ---------------------------------------------------------------------------
module decrypt_requester #(
  parameter int ID_W      = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [ID_W-1:0] job_id,
  output logic            start,
  input  logic            done,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic            resp_timeout,
  output logic [1:0]      resp_attempts,
  output logic            busy,
  output logic            err_spurious
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // The watchdog counts 0 .. TIMEOUT-1 inside one WAIT period.
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // A retry counter of at least one bit keeps MAX_RETRY = 0 legal.
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY);

  state_t          state;
  logic [WD_W-1:0] watchdog;
  logic [RT_W-1:0] retries;

  // NOTE: sequential state uses non-blocking assignments only. The reset
  // branch sits in the same process so that rst acts asynchronously and
  // aborts any in-flight job at once, without producing a response for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      watchdog      <= '0;
      retries       <= '0;
      start         <= 1'b0;
      job_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_timeout  <= 1'b0;
      resp_attempts <= 2'd0;
      err_spurious  <= 1'b0;
    end else begin
      // start is a pulse. It is high only in the cycle that follows a
      // transition into ISSUE.
      start <= 1'b0;

      // A done outside WAIT has no matching request, so it is flagged and
      // otherwise ignored.
      if (done && state != WAIT) begin
        err_spurious <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            resp_id       <= job_id;
            retries       <= '0;
            resp_attempts <= 2'd0;
            resp_timeout  <= 1'b0;
            job_ready     <= 1'b0;
            busy          <= 1'b1;
            start         <= 1'b1;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (resp_attempts != 2'd3) begin
            resp_attempts <= resp_attempts + 2'd1;
          end
          watchdog <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          // done takes priority over watchdog expiry in the same cycle. A late
          // done from an earlier attempt is accepted as completion.
          if (done) begin
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (watchdog == WD_LAST) begin
            if (retries < RT_MAX) begin
              retries <= retries + 1'b1;
              start   <= 1'b1;
              state   <= ISSUE;
            end else begin
              resp_timeout <= 1'b1;
              resp_valid   <= 1'b1;
              state        <= RESP;
            end
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        RESP: begin
          // The response fields stay frozen until upstream takes them.
          // job_ready rises in the same cycle that resp_valid falls.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            job_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
